draw_enemy_sprites: RTL

Renders the four enemy sprites into the VGA frame buffer using the per-enemy colours produced by the enemy-colour update logic. On a start pulse it snapshots the enemy positions, colours and alive mask, then emits one pixel write per cycle (x, y, colour, plot) for every live enemy. A one-cycle done pulse follows the last pixel. The block sits between the game-state/colour logic and the VGA adapter's plot port.

---
 rtl/enemy_draw_pkg.sv | 27 ++
 rtl/draw_enemy_sprites_if.sv | 39 +++
 rtl/pixel_scan_counter.sv | 36 +++
 rtl/draw_enemy_sprites.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/enemy_draw_pkg.sv
// Shared constants, FSM encoding and the live-enemy search helper for the enemy
// sprite renderer.
package enemy_draw_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int C_W          = 3;
  localparam int N_ENEMY      = 4;

  localparam logic [C_W-1:0] BLACK    = 3'b000;
  localparam logic [2:0]     NO_ENEMY = 3'd4;

  typedef enum logic [1:0] {IDLE, SELECT, DRAW, DONE} state_t;

  // Lowest enemy index >= from whose alive bit is set, or NO_ENEMY.
  function automatic logic [2:0] next_alive(input logic [N_ENEMY-1:0] alive,
                                            input logic [2:0]         from);
    logic [2:0] sel;
    sel = NO_ENEMY;
    for (int i = N_ENEMY - 1; i >= 0; i--)
      if (alive[i] && (3'(i) >= from)) sel = 3'(i);
    return sel;
  endfunction

endpackage

// File: rtl/draw_enemy_sprites_if.sv
// Request (enemy snapshot inputs) and pixel-plot bundle between the game logic
// and the sprite renderer; erase exists only when ENEMY_ERASE_EN is defined.
interface draw_enemy_sprites_if;
  import enemy_draw_pkg::*;

  logic               start;
  logic [N_ENEMY-1:0] alive;
  logic [X_W-1:0]     ex1, ex2, ex3, ex4;
  logic [Y_W-1:0]     ey1, ey2, ey3, ey4;
  logic [C_W-1:0]     colour1, colour2, colour3, colour4;
`ifdef ENEMY_ERASE_EN
  logic               erase;
`endif
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [C_W-1:0]     colour;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
`ifdef ENEMY_ERASE_EN
    output erase,
`endif
    output start, alive, ex1, ex2, ex3, ex4, ey1, ey2, ey3, ey4,
           colour1, colour2, colour3, colour4,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
`ifdef ENEMY_ERASE_EN
    input  erase,
`endif
    input  start, alive, ex1, ex2, ex3, ex4, ey1, ey2, ey3, ey4,
           colour1, colour2, colour3, colour4,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/pixel_scan_counter.sv
// SIZE x SIZE raster counter: dx runs fastest, dy advances on dx wrap; last flags
// the final pixel of the sprite.
module pixel_scan_counter #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  localparam logic [2:0] MAX = 3'(SIZE - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (dx == MAX) begin
        dx <= '0;
        dy <= (dy == MAX) ? 3'd0 : dy + 3'd1;
      end else begin
        dx <= dx + 3'd1;
      end
    end
  end

  assign last = (dx == MAX) && (dy == MAX);

endmodule

// File: rtl/draw_enemy_sprites.sv
// Snapshots the four enemies on start and streams one clipped pixel per cycle for
// every live one. Define ENEMY_ERASE_EN to add the erase (draw-in-black) input.
module draw_enemy_sprites
  import enemy_draw_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                 clk,
  input  logic                 resetn,
  draw_enemy_sprites_if.slave  bus
);

  localparam logic [X_W:0] X_LIM = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] Y_LIM = SCREEN_H[Y_W:0];

  state_t state, state_nxt;
  logic   snap, cnt_clear, cnt_en;

  logic [N_ENEMY-1:0] alive_q;
  logic [X_W-1:0]     ex_q  [N_ENEMY];
  logic [Y_W-1:0]     ey_q  [N_ENEMY];
  logic [C_W-1:0]     col_q [N_ENEMY];
`ifdef ENEMY_ERASE_EN
  logic               erase_q;
`endif

  logic [2:0]     idx, sel_idx;
  logic           found;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [C_W-1:0] base_col, pix_col;
  logic [2:0]     dx, dy;
  logic           last;
  logic [X_W:0]   sx;
  logic [Y_W:0]   sy;
  logic           in_range;

  pixel_scan_counter #(.SIZE(SIZE)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  assign sel_idx = next_alive(alive_q, idx);
  assign found   = (sel_idx != NO_ENEMY);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE:   if (bus.start) begin
                snap      = 1'b1;
                state_nxt = SELECT;
              end
      SELECT: if (found) begin
                cnt_clear = 1'b1;
                state_nxt = DRAW;
              end else begin
                state_nxt = DONE;
              end
      DRAW:   begin
                cnt_en = 1'b1;
                if (last) state_nxt = SELECT;
              end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      idx <= '0;
    else if (snap)                    idx <= '0;
    else if (cnt_clear)               idx <= sel_idx;
    else if (state == DRAW && last)   idx <= idx + 3'd1;
  end

  // NOTE: snapshot and base registers carry no reset: each is loaded before it is ever read.
  always_ff @(posedge clk) begin
    if (snap) begin
      alive_q  <= bus.alive;
      ex_q[0]  <= bus.ex1;     ex_q[1]  <= bus.ex2;
      ex_q[2]  <= bus.ex3;     ex_q[3]  <= bus.ex4;
      ey_q[0]  <= bus.ey1;     ey_q[1]  <= bus.ey2;
      ey_q[2]  <= bus.ey3;     ey_q[3]  <= bus.ey4;
      col_q[0] <= bus.colour1; col_q[1] <= bus.colour2;
      col_q[2] <= bus.colour3; col_q[3] <= bus.colour4;
`ifdef ENEMY_ERASE_EN
      erase_q  <= bus.erase;
`endif
    end
    if (cnt_clear) begin
      base_x   <= ex_q[sel_idx[1:0]];
      base_y   <= ey_q[sel_idx[1:0]];
      base_col <= col_q[sel_idx[1:0]];
    end
  end

  // Sums are one bit wider than the ports so off-screen pixels can be detected.
  assign sx       = {1'b0, base_x} + {{(X_W-2){1'b0}}, dx};
  assign sy       = {1'b0, base_y} + {{(Y_W-2){1'b0}}, dy};
  assign in_range = (sx < X_LIM) && (sy < Y_LIM);

`ifdef ENEMY_ERASE_EN
  assign pix_col = erase_q ? BLACK : base_col;
`else
  assign pix_col = base_col;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= BLACK;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.busy <= (state != IDLE);
      bus.done <= (state == DONE);
      bus.plot <= 1'b0;
      if (state == DRAW) begin
        bus.x      <= sx[X_W-1:0];
        bus.y      <= sy[Y_W-1:0];
        bus.colour <= pix_col;
        bus.plot   <= in_range;
      end
    end
  end

endmodule
